// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and datapath widths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_SUM_W     = 32;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus received-byte results; master drives the line, slave is the receiver.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      ser_rx;
  logic                      out_valid;
  logic [UART_DATA_BITS-1:0] out_data;
  logic [UART_SUM_W-1:0]     out_sum;
  logic                      frame_err;

  modport master (
    output ser_rx,
    input  out_valid,
    input  out_data,
    input  out_sum,
    input  frame_err
  );

  modport slave (
    input  ser_rx,
    output out_valid,
    output out_data,
    output out_sum,
    output frame_err
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input; resets to the idle-high level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the pin through two flops before anything downstream uses it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a fixed divisor, byte pulse, running sum and framing error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave rx_if
);

  localparam int CNT_W = $clog2(clocks_per_bit);
  // START is entered one edge after E, so loading H-1 puts the start check at E+H
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((clocks_per_bit / 2) - 1);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(clocks_per_bit - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  rx_state_t                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      out_valid_q, out_valid_d;
  logic [UART_DATA_BITS-1:0] out_data_q, out_data_d;
  logic [UART_SUM_W-1:0]     out_sum_q, out_sum_d;
  logic                      frame_err_q, frame_err_d;
  logic                      rx_s;
  logic                      tick_done_s;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_if.ser_rx),
    .q_o   (rx_s)
  );

  assign tick_done_s = (cnt_q == CNT_ZERO);

  // State, counters, assembly register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sum_q   <= 32'd0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sum_q   <= out_sum_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
        else       state_d = IDLE;
      end
      START: begin
        if (tick_done_s) state_d = rx_s ? IDLE : DATA;
        else             state_d = START;
      end
      DATA: begin
        if (tick_done_s && (idx_q == 3'd7)) state_d = STOP;
        else                                state_d = DATA;
      end
      STOP: begin
        if (tick_done_s) state_d = rx_s ? IDLE : BREAK;
        else             state_d = STOP;
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
        else      state_d = BREAK;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tick counter, bit assembly and result updates
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sum_d   = out_sum_q;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) cnt_d = CNT_HALF;
        else       cnt_d = cnt_q;
      end
      START: begin
        if (tick_done_s) begin
          cnt_d = CNT_BIT;
          idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (tick_done_s) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = CNT_BIT;
          idx_d          = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (tick_done_s) begin
          if (rx_s) begin
            out_valid_d = 1'b1;
            out_data_d  = shift_q;
            out_sum_d   = out_sum_q + UART_SUM_W'(shift_q);
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      BREAK: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = CNT_ZERO;
        idx_d = 3'd0;
      end
    endcase
  end

  assign rx_if.out_valid = out_valid_q;
  assign rx_if.out_data  = out_data_q;
  assign rx_if.out_sum   = out_sum_q;
  assign rx_if.frame_err = frame_err_q;

endmodule
